lfsr_offset_finder: RTL and testbench

- Consumes the decoded 17-bit words from the BMC decoder stage.
- For each word, finds the LFSR polynomial that produced it and the word's step offset from a fixed seed. It steps two candidate 17-bit LFSRs in parallel, one step per clock.
- Outputs a timestamped (poly_id, offset) result that downstream angle computation uses.
- Clears the decoder's sticky data-available flag so the decoder can report the next word.

---
 rtl/lfsr_offset_finder.sv | 175 +++++++++++++++++
 tb/tb_lfsr_offset_finder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_offset_finder.sv
// lfsr_offset_finder
//
// Takes a decoded 17-bit word from the BMC decoder and finds which of two candidate LFSR
// polynomials produced it, and how many steps from SEED it took. Both candidate LFSRs run in
// parallel, one step per clock. The result is tagged with the timestamp captured alongside
// the word.
//
// Ports:
//   clk_96MHz      system clock
//   reset          synchronous, active-low reset
//   enabled        when low, all state is held and the pulse outputs are forced low
//   decoded_data   17-bit word from the decoder
//   data_availible sticky "word ready" level from the decoder
//   ts_last_data   timestamp of decoded_data
//   decoder_clear  one-cycle pulse that clears the decoder's sticky flag
//   busy           high while a search is in progress
//   result_valid   one-cycle pulse; poly_id/offset/match_fail/ts_result are valid
//   match_fail     1 = word not reachable within MAX_ITER steps (or word is zero)
//   poly_id        index of the matching polynomial
//   offset         step count from SEED to the word
//   ts_result      timestamp captured with the word
module lfsr_offset_finder #(
    parameter logic [16:0] POLY_0   = 17'h1D258,
    parameter logic [16:0] POLY_1   = 17'h17E04,
    parameter logic [16:0] SEED     = 17'h00001,
    parameter int unsigned MAX_ITER = 131071
) (
    input  logic        clk_96MHz,
    input  logic        reset,
    input  logic        enabled,
    input  logic [16:0] decoded_data,
    input  logic        data_availible,
    input  logic [23:0] ts_last_data,
    output logic        decoder_clear,
    output logic        busy,
    output logic        result_valid,
    output logic        match_fail,
    output logic        poly_id,
    output logic [16:0] offset,
    output logic [23:0] ts_result
);

    localparam logic [16:0] LastCnt = 17'(MAX_ITER - 1);

    typedef enum logic [0:0] {StIdle, StSearch} state_e;

    state_e      state_q, state_d;
    logic [16:0] word_q, word_d;
    logic [23:0] ts_q, ts_d;
    logic [16:0] st0_q, st0_d;
    logic [16:0] st1_q, st1_d;
    logic [16:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        result_valid_q, result_valid_d;
    logic        decoder_clear_q, decoder_clear_d;
    logic        match_fail_q, match_fail_d;
    logic        poly_id_q, poly_id_d;
    logic [16:0] offset_q, offset_d;
    logic [23:0] ts_result_q, ts_result_d;

    logic search_done, search_fail, match_poly;

    // Feedback bit enters at the LSB.
    function automatic logic [16:0] lfsr_step(input logic [16:0] st, input logic [16:0] poly);
        return {st[15:0], ^(st & poly)};
    endfunction

    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        ts_d            = ts_q;
        st0_d           = st0_q;
        st1_d           = st1_q;
        cnt_d           = cnt_q;
        busy_d          = busy_q;
        match_fail_d    = match_fail_q;
        poly_id_d       = poly_id_q;
        offset_d        = offset_q;
        ts_result_d     = ts_result_q;
        // Pulses drop by default; while disabled they stay dropped so nothing is re-emitted.
        result_valid_d  = 1'b0;
        decoder_clear_d = 1'b0;
        search_done     = 1'b1;
        search_fail     = 1'b0;
        match_poly      = 1'b0;

        // Priority: zero word, poly 0 (wins ties), poly 1, iteration limit.
        if (word_q == '0) begin
            search_fail = 1'b1;
        end else if (st0_q == word_q) begin
            match_poly = 1'b0;
        end else if (st1_q == word_q) begin
            match_poly = 1'b1;
        end else if (cnt_q == LastCnt) begin
            search_fail = 1'b1;
        end else begin
            search_done = 1'b0;
        end

        if (enabled) begin
            unique case (state_q)
                StIdle: begin
                    if (data_availible) begin
                        word_d          = decoded_data;
                        ts_d            = ts_last_data;
                        st0_d           = SEED;
                        st1_d           = SEED;
                        cnt_d           = '0;
                        decoder_clear_d = 1'b1;
                        busy_d          = 1'b1;
                        state_d         = StSearch;
                    end
                end
                StSearch: begin
                    if (search_done) begin
                        result_valid_d = 1'b1;
                        match_fail_d   = search_fail;
                        poly_id_d      = search_fail ? 1'b0 : match_poly;
                        offset_d       = search_fail ? '0 : cnt_q;
                        ts_result_d    = ts_q;
                        busy_d         = 1'b0;
                        state_d        = StIdle;
                    end else begin
                        st0_d = lfsr_step(st0_q, POLY_0);
                        st1_d = lfsr_step(st1_q, POLY_1);
                        cnt_d = cnt_q + 17'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (!reset) begin
            state_q         <= StIdle;
            word_q          <= '0;
            ts_q            <= '0;
            st0_q           <= '0;
            st1_q           <= '0;
            cnt_q           <= '0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            decoder_clear_q <= 1'b0;
            match_fail_q    <= 1'b0;
            poly_id_q       <= 1'b0;
            offset_q        <= '0;
            ts_result_q     <= '0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            ts_q            <= ts_d;
            st0_q           <= st0_d;
            st1_q           <= st1_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            result_valid_q  <= result_valid_d;
            decoder_clear_q <= decoder_clear_d;
            match_fail_q    <= match_fail_d;
            poly_id_q       <= poly_id_d;
            offset_q        <= offset_d;
            ts_result_q     <= ts_result_d;
        end
    end

    // Pulses are masked immediately when the block is disabled.
    assign decoder_clear = decoder_clear_q & enabled;
    assign result_valid  = result_valid_q & enabled;
    assign busy          = busy_q;
    assign match_fail    = match_fail_q;
    assign poly_id       = poly_id_q;
    assign offset        = offset_q;
    assign ts_result     = ts_result_q;

endmodule

// File: tb/tb_lfsr_offset_finder.sv
module tb_lfsr_offset_finder;

    localparam logic [16:0] P0   = 17'h1D258;
    localparam logic [16:0] P1   = 17'h17E04;
    localparam logic [16:0] SEED = 17'h00001;
    localparam int          MAX0 = 131071;
    localparam int          MAX1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enabled;
    logic [16:0] decoded_data;
    logic [23:0] ts_last_data;
    logic        da [2];
    logic        set_req [2];
    logic        clr [2];
    logic        busy [2];
    logic        rv [2];
    logic        mf [2];
    logic        pid [2];
    logic [16:0] off [2];
    logic [23:0] tsr [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_clr [2];
    int n_rv [2];

    always #5 clk = ~clk;

    lfsr_offset_finder #(.MAX_ITER(MAX0)) dut0 (
        .clk_96MHz(clk), .reset(reset), .enabled(enabled), .decoded_data(decoded_data),
        .data_availible(da[0]), .ts_last_data(ts_last_data), .decoder_clear(clr[0]),
        .busy(busy[0]), .result_valid(rv[0]), .match_fail(mf[0]), .poly_id(pid[0]),
        .offset(off[0]), .ts_result(tsr[0])
    );

    lfsr_offset_finder #(.MAX_ITER(MAX1)) dut1 (
        .clk_96MHz(clk), .reset(reset), .enabled(enabled), .decoded_data(decoded_data),
        .data_availible(da[1]), .ts_last_data(ts_last_data), .decoder_clear(clr[1]),
        .busy(busy[1]), .result_valid(rv[1]), .match_fail(mf[1]), .poly_id(pid[1]),
        .offset(off[1]), .ts_result(tsr[1])
    );

    // Decoder model: sticky flag, set by the bench, cleared at the edge that sees decoder_clear.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!reset) da[i] <= 1'b0;
            else if (set_req[i]) da[i] <= 1'b1;
            else if (clr[i]) da[i] <= 1'b0;
            n_clr[i] <= n_clr[i] + (clr[i] ? 1 : 0);
            n_rv[i]  <= n_rv[i] + (rv[i] ? 1 : 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] step(input logic [16:0] s, input logic [16:0] p);
        return {s[15:0], ^(s & p)};
    endfunction

    function automatic logic [16:0] gen_word(input bit p, input int n);
        logic [16:0] s = SEED;
        for (int i = 0; i < n; i++) s = p ? step(s, P1) : step(s, P0);
        return s;
    endfunction

    // Smallest offset at which either sequence hits the word; poly 0 preferred on a tie.
    function automatic void model(input logic [16:0] w, input int maxit, output bit epid,
                                  output int eoff, output bit emf);
        logic [16:0] a = SEED;
        logic [16:0] b = SEED;
        epid = 1'b0;
        eoff = 0;
        emf  = 1'b1;
        if (w == '0) return;
        for (int n = 0; n < maxit; n++) begin
            if (a == w) begin emf = 1'b0; epid = 1'b0; eoff = n; return; end
            if (b == w) begin emf = 1'b0; epid = 1'b1; eoff = n; return; end
            a = step(a, P0);
            b = step(b, P1);
        end
    endfunction

    task automatic post_word(input int s, input logic [16:0] w, input logic [23:0] ts);
        @(negedge clk);
        decoded_data = w;
        ts_last_data = ts;
        set_req[s]   = 1'b1;
        @(negedge clk);
        set_req[s]   = 1'b0;
    endtask

    // One full search with optional 10-cycle disable starting freeze_at cycles after capture.
    task automatic run_search(input int s, input logic [16:0] w, input logic [23:0] ts,
                              input int freeze_at, input string name);
        bit epid, emf;
        int eoff, elat, k, r, nrv0;
        model(w, (s == 0) ? MAX0 : MAX1, epid, eoff, emf);
        elat = emf ? ((w == '0) ? 1 : ((s == 0) ? MAX0 : MAX1)) : eoff + 1;
        if (freeze_at > 0) elat += 10;
        post_word(s, w, ts);
        k = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr[s] === 1'b1) begin k = cyc; break; end
        end
        checks++;
        if (k < 0) begin
            errors++;
            $display("FAIL %s capture: decoder_clear not seen within 4 cycles", name);
            return;
        end
        nrv0 = n_rv[s];
        r = -1;
        for (int i = 1; i <= elat + 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (clr[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s clear_width: decoder_clear=%b second cycle, want 0",
                             name, clr[s]);
                end
            end
            if (rv[s] === 1'b1) begin r = cyc; break; end
            if (freeze_at > 0 && i == freeze_at) begin
                enabled = 1'b0;
                repeat (10) @(negedge clk);
                checks++;
                if (busy[s] !== 1'b1 || rv[s] !== 1'b0 || n_rv[s] != nrv0) begin
                    errors++;
                    $display("FAIL %s freeze: busy=%b rv=%b pulses=%0d, want 1 0 %0d",
                             name, busy[s], rv[s], n_rv[s], nrv0);
                end
                enabled = 1'b1;
            end
        end
        checks++;
        if (r < 0) begin
            errors++;
            $display("FAIL %s timeout: no result_valid within %0d cycles", name, elat + 20);
            return;
        end
        checks++;
        if (r - k != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, r - k, elat);
        end
        checks++;
        if (mf[s] !== emf || off[s] !== 17'(eoff) || tsr[s] !== ts ||
            (!emf && pid[s] !== epid)) begin
            errors++;
            $display("FAIL %s result: mf=%b off=%0d poly=%b ts=%h want mf=%b off=%0d poly=%b ts=%h",
                     name, mf[s], off[s], pid[s], tsr[s], emf, eoff, epid, ts);
        end
        @(negedge clk);
        checks++;
        if (rv[s] !== 1'b0 || busy[s] !== 1'b0) begin
            errors++;
            $display("FAIL %s after: rv=%b busy=%b want 0 0", name, rv[s], busy[s]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (off[s] !== 17'(eoff) || mf[s] !== emf || tsr[s] !== ts) begin
            errors++;
            $display("FAIL %s hold: off=%0d mf=%b ts=%h want %0d %b %h",
                     name, off[s], mf[s], tsr[s], eoff, emf, ts);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        enabled = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({busy[s], rv[s], mf[s], pid[s], clr[s]} !== 5'b0 || off[s] !== '0 ||
                tsr[s] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b rv=%b mf=%b poly=%b clr=%b off=%0d ts=%h want 0",
                         s, busy[s], rv[s], mf[s], pid[s], clr[s], off[s], tsr[s]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_search(0, 17'h00001, 24'h000ABC, 0, "exact_seed");
        run_search(0, 17'h00002, 24'h000DEF, 0, "tie_offset1");
        run_search(0, 17'h00000, 24'h123456, 0, "zero_word");
    endtask

    task automatic test_max_iter();
        run_search(1, 17'h00008, 24'h0000AA, 0, "max_iter");
        run_search(1, 17'h00001, 24'h0000AB, 0, "max_iter_off0");
        run_search(1, 17'h00002, 24'h0000AC, 0, "max_iter_off1");
        run_search(1, 17'h00000, 24'h0000AD, 0, "max_iter_zero");
        for (int i = 0; i < 4; i++)
            run_search(1, 17'($urandom), 24'($urandom), 0, "max_iter_rand");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_search(0, gen_word(1'($urandom_range(0, 1)), $urandom_range(0, 300)),
                       24'($urandom), 0, "rand_match");
    endtask

    task automatic test_reset_mid_search();
        int k, nrv0;
        post_word(0, 17'h10000, 24'h00BEEF);
        k = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr[0] === 1'b1) begin k = cyc; break; end
        end
        checks++;
        if (k < 0) begin
            errors++;
            $display("FAIL reset_mid capture: decoder_clear not seen");
            return;
        end
        nrv0 = n_rv[0];
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || rv[0] !== 1'b0 || off[0] !== '0 || tsr[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid state: busy=%b rv=%b off=%0d ts=%h want 0",
                     busy[0], rv[0], off[0], tsr[0]);
        end
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (n_rv[0] != nrv0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle: pulses=%0d busy=%b want %0d 0",
                     n_rv[0], busy[0], nrv0);
        end
    endtask

    task automatic test_freeze();
        logic [16:0] w = gen_word(1'b1, 40);
        run_search(0, w, 24'h00F00D, 0, "unfrozen");
        run_search(0, w, 24'h00F00E, 15, "frozen");
    endtask

    task automatic test_back_to_back();
        logic [16:0] wa = gen_word(1'b0, 30);
        logic [16:0] wb = gen_word(1'b1, 12);
        logic [16:0] wc = gen_word(1'b1, 25);
        bit epid, emf;
        int eoff, k1, r1, k2, r2, base;
        base = n_clr[0];
        post_word(0, wa, 24'h0000A1);
        k1 = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr[0] === 1'b1) begin k1 = cyc; break; end
        end
        repeat (4) @(negedge clk);
        post_word(0, wb, 24'h0000B2);
        repeat (3) @(negedge clk);
        post_word(0, wc, 24'h0000C3);
        r1 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rv[0] === 1'b1) begin r1 = cyc; break; end
        end
        model(wa, MAX0, epid, eoff, emf);
        checks++;
        if (k1 < 0 || r1 - k1 != eoff + 1 || off[0] !== 17'(eoff) || tsr[0] !== 24'h0000A1) begin
            errors++;
            $display("FAIL b2b first: lat=%0d off=%0d ts=%h want lat=%0d off=%0d ts=0000a1",
                     r1 - k1, off[0], tsr[0], eoff + 1, eoff);
        end
        k2 = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr[0] === 1'b1) begin k2 = cyc; break; end
        end
        checks++;
        if (k2 != r1 + 1) begin
            errors++;
            $display("FAIL b2b recapture: capture edge %0d want %0d", k2, r1 + 1);
        end
        r2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rv[0] === 1'b1) begin r2 = cyc; break; end
        end
        model(wc, MAX0, epid, eoff, emf);
        checks++;
        if (r2 - k2 != eoff + 1 || off[0] !== 17'(eoff) || pid[0] !== epid ||
            tsr[0] !== 24'h0000C3) begin
            errors++;
            $display("FAIL b2b latest: lat=%0d off=%0d poly=%b ts=%h want %0d %0d %b 0000c3",
                     r2 - k2, off[0], pid[0], tsr[0], eoff + 1, eoff, epid);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (n_clr[0] - base != 2 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b captures: got %0d busy=%b want 2 0", n_clr[0] - base, busy[0]);
        end
    endtask

    initial begin
        reset        = 1'b0;
        enabled      = 1'b1;
        decoded_data = '0;
        ts_last_data = '0;
        set_req[0]   = 1'b0;
        set_req[1]   = 1'b0;
        test_reset();
        test_basic();
        test_max_iter();
        test_random();
        test_reset_mid_search();
        test_freeze();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
